// File: rtl/inbox_fifo_pkg.sv
// Shared definitions for the INBOX queue: datapath width and FIFO sizing helpers.
package inbox_fifo_pkg;

  localparam int unsigned INBOX_DATA_W = 8;

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read (distributed-RAM friendly).
module fifo_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32,
  localparam int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AddrW-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AddrW-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inbox_fifo.sv
// First-word-fall-through INBOX queue feeding the control unit; flags decoded from registered count.
module inbox_fifo
  import inbox_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = INBOX_DATA_W,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AFULL_LVL = DEPTH - 4,
  localparam int unsigned CntW     = count_width(DEPTH)
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [CntW-1:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [CntW-1:0] FullCnt  = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfullCnt = CntW'(AFULL_LVL);

  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              almost_full_q, almost_full_d;
  logic              is_empty, is_full;
  logic              push, pop;
  logic [DATA_W-1:0] ram_rdata;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FullCnt);

  // A pop on a full queue frees the head slot in the same cycle, so the push may proceed.
  assign push = wr_en & (~is_full | rd_en) & ~clear;
  assign pop  = rd_en & ~is_empty & ~clear;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AddrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AddrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (wr_en && is_full && !rd_en) begin
        overflow_d = 1'b1;
      end
      if (rd_en && is_empty) begin
        underflow_d = 1'b1;
      end
    end
    almost_full_d = (count_d >= AfullCnt);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      almost_full_q <= almost_full_d;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Storage is not reset, so mask the head while nothing valid is stored.
  assign rd_data     = is_empty ? '0 : ram_rdata;
  assign empty       = is_empty;
  assign full        = is_full;
  assign almost_full = almost_full_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_inbox_fifo.sv
// Directed and randomized checks of inbox_fifo against a queue-based reference model.
module tb_inbox_fifo;

  logic       clk;
  logic       i_rst_n;
  logic       clear;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [5:0] count;
  logic       overflow;
  logic       underflow;

  inbox_fifo dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .clear       (clear),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] q[$];
  bit         m_of;
  bit         m_uf;
  int         n_cmp;
  int         n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] exp_rd;
    int         sz;
    sz     = q.size();
    exp_rd = (sz > 0) ? q[0] : 8'h00;
    chk("rd_data", {24'd0, rd_data}, {24'd0, exp_rd});
    chk("count", {26'd0, count}, sz);
    chk("empty", {31'd0, empty}, {31'd0, sz == 0});
    chk("full", {31'd0, full}, {31'd0, sz == 32});
    chk("almost_full", {31'd0, almost_full}, {31'd0, sz >= 28});
    chk("overflow", {31'd0, overflow}, {31'd0, m_of});
    chk("underflow", {31'd0, underflow}, {31'd0, m_uf});
  endtask

  // One clock cycle: drive inputs, update the model at the edge, check 1 time unit later.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic [7:0] head;
    logic [7:0] exp_pop;
    int         sz;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clear   = c;
    head    = rd_data;
    @(posedge clk);
    sz = q.size();
    if (c) begin
      q.delete();
      m_of = 1'b0;
      m_uf = 1'b0;
    end else begin
      if (r && sz == 0) m_uf = 1'b1;
      if (w && sz == 32 && !r) m_of = 1'b1;
      if (r && sz > 0) begin
        exp_pop = q.pop_front();
        chk("pop_data", {24'd0, head}, {24'd0, exp_pop});
      end
      if (w && (sz < 32 || r)) q.push_back(d);
    end
    #1;
    check_all();
    wr_en = 1'b0;
    rd_en = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    logic w;
    logic r;
    n_cmp   = 0;
    n_err   = 0;
    m_of    = 1'b0;
    m_uf    = 1'b0;
    i_rst_n = 1'b0;
    clear   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rd_en   = 1'b0;

    // Reset state
    #7;
    check_all();
    i_rst_n = 1'b1;

    // 1: basic push/pop
    cyc(1'b1, 8'h05, 1'b0, 1'b0);
    chk("t1_empty_after_push", {31'd0, empty}, 32'd0);
    cyc(1'b1, 8'h12, 1'b0, 1'b0);
    cyc(1'b1, 8'h7F, 1'b0, 1'b0);
    chk("t1_count", {26'd0, count}, 32'd3);
    chk("t1_head", {24'd0, rd_data}, 32'h05);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_pop1", {24'd0, rd_data}, 32'h12);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_pop2", {24'd0, rd_data}, 32'h7F);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_empty", {31'd0, empty}, 32'd1);
    chk("t1_rd_zero", {24'd0, rd_data}, 32'h00);

    // 2: fill, overflow, drain
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 27) chk("t2_afull_28", {31'd0, almost_full}, 32'd1);
      if (i == 26) chk("t2_afull_27", {31'd0, almost_full}, 32'd0);
    end
    chk("t2_full", {31'd0, full}, 32'd1);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("t2_overflow", {31'd0, overflow}, 32'd1);
    chk("t2_count", {26'd0, count}, 32'd32);
    for (int i = 0; i < 32; i++) begin
      chk("t2_drain", {24'd0, rd_data}, i);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // 3: full with simultaneous push and pop
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("t3_head", {24'd0, rd_data}, 32'h00);
    cyc(1'b1, 8'h40, 1'b1, 1'b0);
    chk("t3_count", {26'd0, count}, 32'd32);
    chk("t3_no_overflow", {31'd0, overflow}, 32'd0);
    while (q.size() > 0) begin
      if (q.size() == 1) chk("t3_tail", {24'd0, rd_data}, 32'h40);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // 4: empty with simultaneous push and pop
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h09, 1'b1, 1'b0);
    chk("t4_underflow", {31'd0, underflow}, 32'd1);
    chk("t4_count", {26'd0, count}, 32'd1);
    chk("t4_rd", {24'd0, rd_data}, 32'h09);

    // 5: random interleave across pointer wrap, occupancy held in 1..3
    cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (q.size() <= 1) begin
        w = 1'b1;
        r = (q.size() == 1) ? 1'($urandom % 2) : 1'b0;
      end else if (q.size() >= 3) begin
        r = 1'b1;
        w = 1'($urandom % 2);
      end else begin
        w = 1'($urandom % 2);
        r = 1'($urandom % 2);
      end
      cyc(w, 8'($urandom), r, 1'b0);
    end

    // 6: clear with a pending push, then asynchronous reset mid-stream
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 33; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 27; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_pre_count", {26'd0, count}, 32'd5);
    chk("t6_pre_overflow", {31'd0, overflow}, 32'd1);
    cyc(1'b1, 8'h33, 1'b0, 1'b1);
    chk("t6_clr_count", {26'd0, count}, 32'd0);
    chk("t6_clr_empty", {31'd0, empty}, 32'd1);
    chk("t6_clr_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    #2;
    i_rst_n = 1'b0;
    #1;
    q.delete();
    m_of = 1'b0;
    m_uf = 1'b0;
    check_all();
    #2;
    i_rst_n = 1'b1;
    wr_en   = 1'b0;
    cyc(1'b1, 8'h66, 1'b0, 1'b0);
    chk("t6_post_rst_push", {24'd0, rd_data}, 32'h66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inbox_fifo.md
Name: inbox_fifo

Overview:
- First-word-fall-through FIFO holding the CPU's INBOX queue, directly upstream of the control unit.
- The external source (host loader, UART bridge or testbench) pushes 8-bit words in.
- The control unit pops one word per INBOX instruction via its read strobe.
- `empty` drives the control unit's `inEmpty` input; `rd_data` feeds the register-input mux, so the head word must already be valid in the same cycle the read strobe is asserted.

Parameters:
- DATA_W, 8: word width; matches the CPU datapath.
- DEPTH, 32: number of entries; must be a power of 2, minimum 2.
- AFULL_LVL, DEPTH-4: occupancy at or above which `almost_full` asserts.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush.
- wr_en  in  1  push strobe from the external source.
- wr_data  in  DATA_W  word to push.
- rd_en  in  1  pop strobe from the control unit (its rIn).
- rd_data  out  DATA_W  head word (FWFT).
- empty  out  1  no words stored; to control unit inEmpty.
- full  out  1  DEPTH words stored.
- almost_full  out  1  count >= AFULL_LVL.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop was ignored.

Behaviour:
- **Reset** (i_rst_n low, asynchronous, takes effect immediately):
  - pointers = 0, count = 0, empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0, rd_data = 0.
  - Storage array contents are not reset.
- **Storage:** DEPTH x DATA_W array.
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Occupancy is held in an explicit `count` register of width $clog2(DEPTH)+1.
  - empty = (count == 0); full = (count == DEPTH). Both are decoded from registered `count`, so there are no combinational paths from wr_en or rd_en.
- **rd_data:**
  - When not empty, rd_data = mem[rd_ptr], combinational from the registered pointer and array.
  - When empty, rd_data is forced to 0.
  - A word written at edge N appears on rd_data, with empty = 0, after edge N (1-cycle write-to-visible latency).
- **Push** (wr_en & ~full): mem[wr_ptr] <= wr_data; wr_ptr += 1.
- **Pop** (rd_en & ~empty): rd_ptr += 1. The consumer samples rd_data in the same cycle it asserts rd_en.
- **Count update:** +1 on push only, -1 on pop only, unchanged when both occur or neither occurs.
- **Simultaneous push and pop, non-empty and not full:** both are performed; count is unchanged.
- **Full with push and pop in the same cycle:** both are performed (the pop frees a slot in that cycle); count stays DEPTH and overflow is not set.
- **Full with push only:** the word is dropped, state is unchanged, overflow <= 1.
- **Empty with push and pop in the same cycle:** the push is performed and the pop is ignored; underflow <= 1; count becomes 1.
- **Empty with pop only:** ignored; underflow <= 1.
  - Under correct control-unit operation this never occurs, because the control unit waits on inEmpty.
- **Sticky flags:** overflow and underflow stay set until reset or clear.
- **clear:** highest priority; overrides wr_en and rd_en in that cycle.
  - Pointers, count, overflow and underflow go to 0; empty = 1 the next cycle.
  - Array contents are not cleared.
- **Reset mid-operation:** any in-flight push or pop is lost; state returns to reset values immediately.
  - After i_rst_n deasserts, the first rising edge may accept a push.
- **almost_full:** registered compare of next-count against AFULL_LVL, so it is aligned with `count`.

Decomposition:
- Shared package holds:
  - DATA_W default (8), shared with the CPU datapath.
  - The count-width function, $clog2(DEPTH)+1.
- One natural sub-module, `fifo_ram`: a simple dual-port array with synchronous write and asynchronous read.
  - Kept separate so it can map to distributed RAM on iCE40.
  - Pointer, count and flag logic stays in `inbox_fifo`.

Test Plan:
1. Reset, then push 0x05, 0x12, 0x7F on consecutive cycles. Expect empty=0 one cycle after the first push, count=3, rd_data=0x05; each pop gives 0x12, then 0x7F; empty=1 after the third pop; rd_data=0.
2. Fill 32 pushes (values 0..31): full=1, count=32, almost_full set once count=28. A 33rd push of 0xAA gives overflow=1 with count still 32. Draining gives 0..31 in order, with no 0xAA.
3. Full FIFO, push 0x40 and pop in the same cycle: popped word = 0; count stays 32; overflow=0; the tail word is 0x40 after a full drain.
4. Empty FIFO, push 0x09 and pop in the same cycle: underflow=1, count=1, rd_data=0x09 next cycle.
5. Wrap-around: 100 interleaved push/pop cycles holding count between 1 and 3. Every popped value matches a scoreboard across pointer wrap.
6. With count=5, overflow=1 and wr_en high, assert clear: next cycle count=0, empty=1, overflow=0, and the concurrent push is dropped. Pulse i_rst_n low mid-stream: outputs go to reset values before the next clock edge.
